// File: rtl/regfile_wr_sched_pkg.sv
// Shared widths and the port identifier used by the write-port arbiter.
package regfile_pkg;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_e;
endpackage

// File: rtl/regfile_wr_sched_if.sv
// Bundle of reservation, query, writeback and register-file write signals.
interface regfile_wr_sched_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          rsv_valid;
   logic [AW-1:0] rsv_addr;
   logic          flush;
   logic [AW-1:0] rsc;
   logic [AW-1:0] rtc;
   logic          rs_busy;
   logic          rt_busy;
   logic          a_valid;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_data;
   logic          a_ready;
   logic          b_valid;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_data;
   logic          b_ready;
   logic          RF_w;
   logic [AW-1:0] rdc;
   logic [DW-1:0] rd;

   modport master (
      output rsv_valid, rsv_addr, flush, rsc, rtc,
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  rs_busy, rt_busy, a_ready, b_ready, RF_w, rdc, rd
   );

   modport slave (
      input  rsv_valid, rsv_addr, flush, rsc, rtc,
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output rs_busy, rt_busy, a_ready, b_ready, RF_w, rdc, rd
   );
endinterface

// File: rtl/regfile_wr_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the port that wins a tie.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   port_e ptr_q, ptr_d;

   always_comb begin
      gnt_o    = 2'b00;
      ptr_d    = ptr_q;
      gnt_o[0] = req_i[0] & (~req_i[1] | (ptr_q == PORT_A));
      gnt_o[1] = req_i[1] & (~req_i[0] | (ptr_q == PORT_B));
      // After a grant the other port gets the next tie.
      if (gnt_o[0]) begin
         ptr_d = PORT_B;
      end else if (gnt_o[1]) begin
         ptr_d = PORT_A;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= PORT_A;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file plus the pending-write scoreboard
// that decode queries for read-after-write stalls.
module regfile_wr_sched
   import regfile_pkg::*;
#(
   parameter int AW = regfile_pkg::AW,
   parameter int DW = regfile_pkg::DW
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_wr_sched_if.slave  bus
);
   localparam int NR = 1 << AW;

   logic [1:0]    gnt;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rf_w_q, rf_w_d;
   logic [AW-1:0] rdc_q, rdc_d;
   logic [DW-1:0] rd_q, rd_d;
   logic [NR-1:0] busy_q, busy_d;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i ({bus.b_valid, bus.a_valid}),
      .gnt_o (gnt)
   );

   assign bus.a_ready = gnt[0];
   assign bus.b_ready = gnt[1];

   always_comb begin
      wr_addr = bus.a_addr;
      wr_data = bus.a_data;
      if (gnt[1]) begin
         wr_addr = bus.b_addr;
         wr_data = bus.b_data;
      end
      // Writes to r0 complete the handshake but never reach the file.
      rf_w_d = (|gnt) && (wr_addr != '0);
      rdc_d  = rf_w_d ? wr_addr : rdc_q;
      rd_d   = rf_w_d ? wr_data : rd_q;
   end

   always_comb begin
      busy_d = busy_q;
      if (rf_w_q) begin
         busy_d[rdc_q] = 1'b0;
      end
      // A reservation is newer than the write retiring this edge, so it wins.
      if (bus.rsv_valid && (bus.rsv_addr != '0)) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_w_q <= 1'b0;
         rdc_q  <= '0;
         rd_q   <= '0;
         busy_q <= '0;
      end else begin
         rf_w_q <= rf_w_d;
         rdc_q  <= rdc_d;
         rd_q   <= rd_d;
         busy_q <= busy_d;
      end
   end

   assign bus.RF_w    = rf_w_q;
   assign bus.rdc     = rdc_q;
   assign bus.rd      = rd_q;
   assign bus.rs_busy = busy_q[bus.rsc];
   assign bus.rt_busy = busy_q[bus.rtc];
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched: inputs change on the falling edge and
// outputs are sampled shortly after, well away from the rising edge.
module tb_regfile_wr_sched;
   import regfile_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   regfile_wr_sched_if #(.AW(5), .DW(32)) ifc ();

   regfile_wr_sched #(.AW(5), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Issue must stall on write-after-write: never reserve an already busy register.
   always @(posedge clk) begin
      if (rst_n && ifc.rsv_valid && (ifc.rsv_addr != 5'd0)) begin
         assert (!dut.busy_q[ifc.rsv_addr])
            else $error("reservation of busy register r%0d", ifc.rsv_addr);
      end
   end

   task automatic idle();
      ifc.rsv_valid = 1'b0;
      ifc.rsv_addr  = '0;
      ifc.flush     = 1'b0;
      ifc.rsc       = '0;
      ifc.rtc       = '0;
      ifc.a_valid   = 1'b0;
      ifc.a_addr    = '0;
      ifc.a_data    = '0;
      ifc.b_valid   = 1'b0;
      ifc.b_addr    = '0;
      ifc.b_data    = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      if (ifc.RF_w !== 1'b0) begin n_err++; $display("FAIL reset_RF_w: got %0h want 0", ifc.RF_w); end
      n_cmp++;
      if (ifc.rdc !== 5'd0) begin n_err++; $display("FAIL reset_rdc: got %0h want 0", ifc.rdc); end
      n_cmp++;
      if (ifc.rd !== 32'd0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", ifc.rd); end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      if (ifc.a_ready !== 1'b0 || ifc.b_ready !== 1'b0) begin
         n_err++; $display("FAIL idle_ready: got a=%0b b=%0b want 0 0", ifc.a_ready, ifc.b_ready);
      end
      n_cmp++;
      for (int i = 0; i < 32; i++) begin
         ifc.rsc = 5'(i);
         ifc.rtc = 5'(31 - i);
         #1;
         if (ifc.rs_busy !== 1'b0 || ifc.rt_busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy_%0d: got rs=%0b rt=%0b want 0 0", i, ifc.rs_busy, ifc.rt_busy);
         end
         n_cmp++;
      end
      idle();
   endtask

   task automatic test_raw();
      @(negedge clk);
      ifc.rsv_valid = 1'b1;
      ifc.rsv_addr  = 5'd5;
      @(negedge clk);
      ifc.rsv_valid = 1'b0;
      ifc.rsc       = 5'd5;
      #1;
      if (ifc.rs_busy !== 1'b1) begin n_err++; $display("FAIL raw_reserved: got %0b want 1", ifc.rs_busy); end
      n_cmp++;
      @(negedge clk);
      ifc.a_valid = 1'b1;
      ifc.a_addr  = 5'd5;
      ifc.a_data  = 32'h1234;
      #1;
      if (ifc.a_ready !== 1'b1) begin n_err++; $display("FAIL raw_a_ready: got %0b want 1", ifc.a_ready); end
      n_cmp++;
      if (ifc.rs_busy !== 1'b1) begin n_err++; $display("FAIL raw_busy_N: got %0b want 1", ifc.rs_busy); end
      n_cmp++;
      @(negedge clk);
      ifc.a_valid = 1'b0;
      #1;
      if (ifc.RF_w !== 1'b1 || ifc.rdc !== 5'd5 || ifc.rd !== 32'h1234) begin
         n_err++; $display("FAIL raw_cmd_N1: got w=%0b rdc=%0d rd=%h want 1 5 00001234", ifc.RF_w, ifc.rdc, ifc.rd);
      end
      n_cmp++;
      if (ifc.rs_busy !== 1'b1) begin n_err++; $display("FAIL raw_busy_N1: got %0b want 1", ifc.rs_busy); end
      n_cmp++;
      @(negedge clk);
      #1;
      if (ifc.rs_busy !== 1'b0) begin n_err++; $display("FAIL raw_busy_N2: got %0b want 0", ifc.rs_busy); end
      n_cmp++;
      if (ifc.RF_w !== 1'b0 || ifc.rdc !== 5'd5 || ifc.rd !== 32'h1234) begin
         n_err++; $display("FAIL raw_hold_N2: got w=%0b rdc=%0d rd=%h want 0 5 00001234", ifc.RF_w, ifc.rdc, ifc.rd);
      end
      n_cmp++;
      idle();
   endtask

   task automatic test_r0_write();
      @(negedge clk);
      ifc.b_valid = 1'b1;
      ifc.b_addr  = 5'd0;
      ifc.b_data  = 32'hFFFF_FFFF;
      #1;
      if (ifc.b_ready !== 1'b1 || ifc.a_ready !== 1'b0) begin
         n_err++; $display("FAIL r0_ready: got a=%0b b=%0b want 0 1", ifc.a_ready, ifc.b_ready);
      end
      n_cmp++;
      @(negedge clk);
      idle();
      #1;
      if (ifc.RF_w !== 1'b0) begin n_err++; $display("FAIL r0_RF_w: got %0b want 0", ifc.RF_w); end
      n_cmp++;
      if (ifc.rdc !== 5'd5 || ifc.rd !== 32'h1234) begin
         n_err++; $display("FAIL r0_hold: got rdc=%0d rd=%h want 5 00001234", ifc.rdc, ifc.rd);
      end
      n_cmp++;
      if (ifc.rs_busy !== 1'b0) begin n_err++; $display("FAIL r0_busy: got %0b want 0", ifc.rs_busy); end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      logic          exp_a;
      logic [4:0]    exp_rdc;
      logic [31:0]   exp_rd;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            ifc.a_valid = 1'b1;
            ifc.a_addr  = 5'd1;
            ifc.a_data  = 32'hA000 + 32'(i);
            ifc.b_valid = 1'b1;
            ifc.b_addr  = 5'd2;
            ifc.b_data  = 32'hB000 + 32'(i);
         end else begin
            idle();
         end
         #1;
         if (i < 4) begin
            exp_a = (i % 2 == 0);
            if (ifc.a_ready !== exp_a || ifc.b_ready !== !exp_a) begin
               n_err++; $display("FAIL rr_grant_%0d: got a=%0b b=%0b want %0b %0b", i, ifc.a_ready, ifc.b_ready, exp_a, !exp_a);
            end
            n_cmp++;
         end
         if (i > 0) begin
            exp_rdc = ((i - 1) % 2 == 0) ? 5'd1 : 5'd2;
            exp_rd  = ((i - 1) % 2 == 0) ? (32'hA000 + 32'(i - 1)) : (32'hB000 + 32'(i - 1));
            if (ifc.RF_w !== 1'b1 || ifc.rdc !== exp_rdc || ifc.rd !== exp_rd) begin
               n_err++; $display("FAIL rr_cmd_%0d: got w=%0b rdc=%0d rd=%h want 1 %0d %h", i, ifc.RF_w, ifc.rdc, ifc.rd, exp_rdc, exp_rd);
            end
            n_cmp++;
         end
      end
   endtask

   task automatic test_set_clear_flush();
      @(negedge clk);
      ifc.a_valid = 1'b1;
      ifc.a_addr  = 5'd7;
      ifc.a_data  = 32'h77;
      @(negedge clk);
      idle();
      ifc.rsv_valid = 1'b1;
      ifc.rsv_addr  = 5'd7;
      ifc.rsc       = 5'd7;
      #1;
      if (ifc.RF_w !== 1'b1 || ifc.rdc !== 5'd7) begin
         n_err++; $display("FAIL setclr_cmd: got w=%0b rdc=%0d want 1 7", ifc.RF_w, ifc.rdc);
      end
      n_cmp++;
      @(negedge clk);
      ifc.rsv_valid = 1'b0;
      #1;
      if (ifc.rs_busy !== 1'b1) begin n_err++; $display("FAIL set_wins: got %0b want 1", ifc.rs_busy); end
      n_cmp++;
      @(negedge clk);
      ifc.flush     = 1'b1;
      ifc.rsv_valid = 1'b1;
      ifc.rsv_addr  = 5'd9;
      ifc.rtc       = 5'd9;
      @(negedge clk);
      ifc.flush     = 1'b0;
      ifc.rsv_valid = 1'b0;
      #1;
      if (ifc.rs_busy !== 1'b0 || ifc.rt_busy !== 1'b0) begin
         n_err++; $display("FAIL flush: got r7=%0b r9=%0b want 0 0", ifc.rs_busy, ifc.rt_busy);
      end
      n_cmp++;
      idle();
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      ifc.a_valid = 1'b1;
      ifc.a_addr  = 5'd3;
      ifc.a_data  = 32'h33;
      @(negedge clk);
      idle();
      #1;
      if (ifc.RF_w !== 1'b1 || ifc.rdc !== 5'd3) begin
         n_err++; $display("FAIL prerst_cmd: got w=%0b rdc=%0d want 1 3", ifc.RF_w, ifc.rdc);
      end
      n_cmp++;
      #1;
      rst_n = 1'b0;
      #1;
      if (ifc.RF_w !== 1'b0 || ifc.rdc !== 5'd0 || ifc.rd !== 32'd0) begin
         n_err++; $display("FAIL async_rst: got w=%0b rdc=%0d rd=%h want 0 0 0", ifc.RF_w, ifc.rdc, ifc.rd);
      end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ifc.a_valid = 1'b1;
      ifc.a_addr  = 5'd1;
      ifc.a_data  = 32'h11;
      ifc.b_valid = 1'b1;
      ifc.b_addr  = 5'd2;
      ifc.b_data  = 32'h22;
      #1;
      if (ifc.a_ready !== 1'b1 || ifc.b_ready !== 1'b0) begin
         n_err++; $display("FAIL rst_ptr: got a=%0b b=%0b want 1 0", ifc.a_ready, ifc.b_ready);
      end
      n_cmp++;
      @(negedge clk);
      idle();
      #1;
      if (ifc.RF_w !== 1'b1 || ifc.rdc !== 5'd1 || ifc.rd !== 32'h11) begin
         n_err++; $display("FAIL rst_cmd: got w=%0b rdc=%0d rd=%h want 1 1 00000011", ifc.RF_w, ifc.rdc, ifc.rd);
      end
      n_cmp++;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_raw();
      test_r0_write();
      test_back_to_back();
      test_set_clear_flush();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_wr_sched.md
# regfile_wr_sched

Write-port scheduler and pending-write scoreboard for the 32×32 register file (one write port, two async read ports, register 0 hard-wired to zero). Arbitrates two writeback requesters onto the single write port with round-robin fairness and drives the file's write-enable, write-address and write-data inputs from registers. Tracks destinations reserved at issue so the decode stage can stall on read-after-write hazards.

## Interface
- `AW`, default 5, register address width
- `DW`, default 32, data width
- `clk` in 1, clock; the register file samples the write command on the same rising edge
- `rst_n` in 1, asynchronous, active-low reset
- `rsv_valid` in 1, issue stage reserves a destination this cycle
- `rsv_addr` in AW, destination being reserved
- `flush` in 1, clear all reservations (pipeline squash)
- `rsc`, `rtc` in AW, source addresses queried by decode
- `rs_busy`, `rt_busy` out 1, combinational: source has a pending write
- `a_valid` in 1, `a_addr` in AW, `a_data` in DW, `a_ready` out 1, port A (ALU writeback)
- `b_valid` in 1, `b_addr` in AW, `b_data` in DW, `b_ready` out 1, port B (load/multi-cycle writeback)
- `RF_w` out 1, `rdc` out AW, `rd` out DW, registered write command to the register file

## Operation
- Handshake: a transfer on a port occurs in a cycle where valid and ready are both 1. Ready is combinational from both valids and the priority pointer. Ready is never 1 when the port's own valid is 0.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid: the pointer's port is granted.
  - After any grant, the pointer moves to the non-granted port.
  - The pointer holds when there is no grant.
- Write command: on a transfer with addr≠0, the next edge loads `RF_w`=1, `rdc`=addr, `rd`=data. On a transfer with addr=0, or with no transfer, `RF_w` is loaded with 0. `rdc`/`rd` then hold their previous values.
- Scoreboard, 32 busy bits; bit 0 is constant 0:
  - Set: `rsv_valid` with `rsv_addr`≠0 sets bit[`rsv_addr`].
  - Clear: `RF_w`=1 clears bit[`rdc`] at the same edge the file performs the write.
  - Same register set and cleared in one cycle: set wins, because the reservation is newer.
  - `flush`=1 clears all bits. It overrides any set in the same cycle. It does not cancel a write command already on `RF_w`.
- Queries: `rs_busy` = bit[`rsc`]; `rt_busy` = bit[`rtc`]. Both are combinational and reflect the current register state only, with no bypass.
- Reserving a register that is already busy is illegal. Issue must stall on write-after-write. The bench asserts this never happens.
- Writebacks to a register that is not reserved are legal. They are written, and clearing a 0 bit is a no-op.

## Timing
- Reset (async, `rst_n`=0): `RF_w`=0, `rdc`=0, `rd`=0, all busy bits 0, pointer = A. `a_ready`/`b_ready` follow their valids combinationally.
- Latency:
  - Transfer in cycle N → `RF_w`=1 during cycle N+1.
  - Register file updated at the end-of-N+1 edge.
  - Busy bit clear at that same edge.
  - `rs_busy` low and correct read data available in cycle N+2.
- Throughput: one write per cycle sustained. The losing port waits at most one cycle under continuous contention.
- Reset asserted mid-transfer: any pending `RF_w` is dropped, the write is lost, and the pointer returns to A.

## Structure
- Package `regfile_pkg`: `AW`, `DW`, `NREG`=32, and the port-id enum `PORT_A`/`PORT_B` used for the pointer.
- Sub-module `rr_arb2`: 2-requester round-robin arbiter. Inputs are the two requests; outputs are the one-hot grant; it contains the pointer flop.
- The scoreboard and the write-command register live in the top level.

## Test plan
- Reset then idle: `RF_w`=0, `rdc`=0, `rd`=0; `rs_busy`=`rt_busy`=0 for all `rsc`/`rtc`; `a_ready`=`b_ready`=0.
- Reserve r5, then port A writes r5=0x1234 in cycle N: `rs_busy`(rsc=5)=1 until cycle N+1 inclusive. `RF_w`=1, `rdc`=5, `rd`=0x1234 in N+1. `rs_busy`=0 in N+2.
- Both ports valid for 4 cycles (A→r1, B→r2, fresh data each cycle): grants alternate A,B,A,B. `RF_w` stays 1 throughout, with `rdc` sequence 1,2,1,2.
- Port B writes r0=0xFFFFFFFF: `b_ready`=1 and the handshake completes. `RF_w`=0 next cycle; busy bit 0 stays 0.
- Same cycle: `rsv_valid` r7 and `RF_w`=1 with `rdc`=7 → bit 7 is 1 afterwards. Then `flush` together with `rsv_valid` r9 → all bits 0, including 7 and 9.
- `rst_n` pulsed low while `RF_w`=1 and the pointer is at B: outputs go to 0 immediately and the next contended grant goes to A.
